// File: rtl/game_defs.sv
// Shared encodings for the tug-of-war match sequencer.
package game_defs;

  typedef enum logic [2:0] {
    ST_IDLE         = 3'd0,
    ST_TUG_RUN      = 3'd1,
    ST_CHECK        = 3'd2,
    ST_SPEED_LAUNCH = 3'd3,
    ST_SPEED_RUN    = 3'd4,
    ST_SPEED_EXIT   = 3'd5,
    ST_GAME_OVER    = 3'd6,
    ST_FAULT        = 3'd7
  } state_t;

  localparam logic [1:0] WIN_NONE  = 2'b00;
  localparam logic [1:0] WIN_LEFT  = 2'b01;
  localparam logic [1:0] WIN_RIGHT = 2'b10;

  localparam int DEF_WIN_SCORE    = 5;
  localparam int DEF_SPEED_POINTS = 2;

endpackage

// File: rtl/sat_score_ctr.sv
// Score register: saturating add of 1 or POINTS, synchronous clear.
module sat_score_ctr #(
  parameter int W      = 4,
  parameter int POINTS = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         add_one,
  input  logic         add_pts,
  output logic [W-1:0] score
);

  localparam logic [W:0] MAX = {1'b0, {W{1'b1}}};

  logic [W-1:0] score_q;
  logic [W-1:0] score_d;
  logic [W:0]   inc;
  logic [W:0]   sum;

  always_comb begin
    inc = '0;
    if (add_pts) begin
      inc = (W+1)'(POINTS);
    end else if (add_one) begin
      inc = (W+1)'(1);
    end
    // one guard bit so an overflow clamps instead of wrapping
    sum = {1'b0, score_q} + inc;
    score_d = score_q;
    if (clr) begin
      score_d = '0;
    end else if (sum > MAX) begin
      score_d = '1;
    end else begin
      score_d = sum[W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      score_q <= '0;
    end else begin
      score_q <= score_d;
    end
  end

  assign score = score_q;

endmodule

// File: rtl/match_sequencer.sv
// Match scheduler: normal tug rounds, periodic speed rounds, scoring,
// winner detection and a speed-round timeout watchdog.
module match_sequencer
  import game_defs::*;
#(
  parameter int SCORE_W       = 4,
  parameter int WIN_SCORE     = DEF_WIN_SCORE,
  parameter int SPEED_EVERY   = 2,
  parameter int SPEED_POINTS  = DEF_SPEED_POINTS,
  parameter int TIMEOUT_TICKS = 63
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               slowen,
  input  logic               start,
  input  logic               tug_done,
  input  logic               tug_left_won,
  input  logic               winspeed,
  input  logic               speed_right,
  input  logic               speed_tie,
  input  logic               speed_exit,
  output logic               tug_enable,
  output logic               speed_round,
  output logic [SCORE_W-1:0] score_left,
  output logic [SCORE_W-1:0] score_right,
  output logic               match_over,
  output logic [1:0]         match_winner,
  output logic               fault
);

  localparam int RND_W = 4;
  localparam int TO_W  = $clog2(TIMEOUT_TICKS + 1);

  localparam logic [RND_W-1:0] RND_LAST =
    RND_W'(SPEED_EVERY);
  localparam logic [TO_W-1:0] TO_LAST =
    TO_W'(TIMEOUT_TICKS - 1);
  localparam logic [SCORE_W-1:0] WIN_VAL =
    SCORE_W'(WIN_SCORE);

  state_t           state_q, state_d;
  logic [RND_W-1:0] rnd_q, rnd_d;
  logic [TO_W-1:0]  to_q, to_d;

  logic       tug_enable_q, tug_enable_d;
  logic       speed_round_q, speed_round_d;
  logic       match_over_q, match_over_d;
  logic [1:0] match_winner_q, match_winner_d;
  logic       fault_q, fault_d;

  logic clr_sc;
  logic l_one, r_one, l_pts, r_pts;
  logic left_win, right_win;
  logic to_hit;

  assign left_win  = score_left >= WIN_VAL;
  assign right_win = score_right >= WIN_VAL;

  always_comb begin
    state_d = state_q;
    rnd_d   = rnd_q;
    to_d    = to_q;
    clr_sc  = 1'b0;
    l_one   = 1'b0;
    r_one   = 1'b0;
    l_pts   = 1'b0;
    r_pts   = 1'b0;
    to_hit  = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_GAME_OVER, ST_FAULT: begin
        if (start) begin
          state_d = ST_TUG_RUN;
          clr_sc  = 1'b1;
          rnd_d   = '0;
        end
      end
      ST_TUG_RUN: begin
        if (tug_done) begin
          l_one   = tug_left_won;
          r_one   = !tug_left_won;
          rnd_d   = rnd_q + RND_W'(1);
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (left_win || right_win) begin
          state_d = ST_GAME_OVER;
        end else if (rnd_q == RND_LAST) begin
          rnd_d   = '0;
          state_d = ST_SPEED_LAUNCH;
        end else begin
          state_d = ST_TUG_RUN;
        end
      end
      ST_SPEED_LAUNCH: begin
        to_d    = '0;
        state_d = ST_SPEED_RUN;
      end
      ST_SPEED_RUN: begin
        if (slowen) begin
          to_d   = to_q + TO_W'(1);
          to_hit = to_q >= TO_LAST;
        end
        // watchdog wins over a result arriving on the same cycle
        if (to_hit) begin
          state_d = ST_FAULT;
        end else if (winspeed) begin
          r_pts   = !speed_tie && speed_right;
          l_pts   = !speed_tie && !speed_right;
          state_d = speed_exit ? ST_CHECK : ST_SPEED_EXIT;
        end
      end
      ST_SPEED_EXIT: begin
        if (slowen) begin
          to_d   = to_q + TO_W'(1);
          to_hit = to_q >= TO_LAST;
        end
        if (to_hit) begin
          state_d = ST_FAULT;
        end else if (speed_exit) begin
          state_d = ST_CHECK;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    tug_enable_d   = state_d == ST_TUG_RUN;
    speed_round_d  = state_d == ST_SPEED_LAUNCH;
    match_over_d   = state_d == ST_GAME_OVER;
    fault_d        = state_d == ST_FAULT;
    match_winner_d = WIN_NONE;
    if (state_d == ST_GAME_OVER) begin
      if (left_win) begin
        match_winner_d = WIN_LEFT;
      end else if (right_win) begin
        match_winner_d = WIN_RIGHT;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      rnd_q          <= '0;
      to_q           <= '0;
      tug_enable_q   <= 1'b0;
      speed_round_q  <= 1'b0;
      match_over_q   <= 1'b0;
      match_winner_q <= WIN_NONE;
      fault_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      rnd_q          <= rnd_d;
      to_q           <= to_d;
      tug_enable_q   <= tug_enable_d;
      speed_round_q  <= speed_round_d;
      match_over_q   <= match_over_d;
      match_winner_q <= match_winner_d;
      fault_q        <= fault_d;
    end
  end

  sat_score_ctr #(
    .W      (SCORE_W),
    .POINTS (SPEED_POINTS)
  ) u_left (
    .clk     (clk),
    .rst     (rst),
    .clr     (clr_sc),
    .add_one (l_one),
    .add_pts (l_pts),
    .score   (score_left)
  );

  sat_score_ctr #(
    .W      (SCORE_W),
    .POINTS (SPEED_POINTS)
  ) u_right (
    .clk     (clk),
    .rst     (rst),
    .clr     (clr_sc),
    .add_one (r_one),
    .add_pts (r_pts),
    .score   (score_right)
  );

  assign tug_enable   = tug_enable_q;
  assign speed_round  = speed_round_q;
  assign match_over   = match_over_q;
  assign match_winner = match_winner_q;
  assign fault        = fault_q;

endmodule
